fifo_bram_packet_writer: RTL and testbench
==========================================

# fifo_bram_packet_writer

Drains the 64-bit packet FIFO that the acquisition core fills and writes its contents as 32-bit words into a dual-port BRAM ring buffer that the PS reads. Space is reserved for a whole packet before any of it is written. The PS-visible write pointer advances only when a packet is complete, so software never sees a partial packet. Packets that do not fit, or that are longer than configured, are discarded and counted.

## Interface
- `BRAM_ADDR_WIDTH`, 14, BRAM word-address width; ring depth is 2^BRAM_ADDR_WIDTH 32-bit words.
- `PACKET_WORDS`, 74, maximum packet length in 32-bit words (2 header + 35 data 64-bit words); this is the space reserved per packet.
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: permits starting new packets; sampled only at packet boundaries.
- `clear_stats` in 1: single-cycle pulse; clears counters and sticky flags.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_read_en` out 1: FIFO pop; read latency is 1 cycle.
- `fifo_read_data` in 64: FIFO word; bits [31:0] go to BRAM first.
- `fifo_read_end_flag` in 1: stored with each word; 1 marks the last word of a packet.
- `bram_en` out 1: BRAM port enable, equal to `bram_we`.
- `bram_we` out 1: BRAM write strobe.
- `bram_addr` out BRAM_ADDR_WIDTH: BRAM word address.
- `bram_wdata` out 32: BRAM write data.
- `ps_read_ptr` in BRAM_ADDR_WIDTH: next word the PS will read.
- `committed_write_ptr` out BRAM_ADDR_WIDTH: one past the last word of the last complete packet.
- `packets_written` out 32: count of complete packets committed.
- `packets_dropped` out 32: count of packets discarded, whether for no space or for length error.
- `overflow_sticky` out 1: set when a packet is dropped for lack of space.
- `length_error_sticky` out 1: set when a packet exceeds PACKET_WORDS.
- `in_packet` out 1: a packet is in progress (being written or being dropped).

## Operation
- FSM states:
  - IDLE: if `!fifo_empty && (in_packet || enable)`, go to FETCH.
  - FETCH: `fifo_read_en`=1 for exactly one cycle, then go to LATCH.
  - LATCH: capture data and end flag into registers.
    - If `!in_packet`, run the admission check, then set `in_packet`.
    - Admit: go to WR_LO.
    - Drop: set `drop` and go to DRAIN.
    - If already `in_packet`, go to WR_LO, or to DRAIN when `drop`=1.
  - WR_LO: write the low half at `wr_ptr`; `wr_ptr`+1.
  - WR_HI: write the high half at `wr_ptr`; `wr_ptr`+1; then apply the end check.
  - DRAIN: no BRAM write; apply the end check.
- Admission check:
  - free = (`ps_read_ptr` − `committed_write_ptr` − 1) mod 2^BRAM_ADDR_WIDTH.
  - Admit iff free ≥ PACKET_WORDS; otherwise drop.
  - One slot is always left empty, so equal pointers mean the ring is empty.
- End check:
  - End flag set and not dropping: `committed_write_ptr` <= `wr_ptr` (value after the increment); `packets_written`+1; clear `in_packet`.
  - End flag set while dropping: `packets_dropped`+1; clear `in_packet` and `drop`.
  - Then go to FETCH if `!fifo_empty && (in_packet_next || enable)`, else IDLE.
- Length guard: at WR_LO, if the packet word count already equals PACKET_WORDS, do not write. Instead:
  - set `length_error_sticky`;
  - roll `wr_ptr` back to `committed_write_ptr`;
  - set `drop` and go to DRAIN. The packet is counted as dropped at its end flag.
- Pointer arithmetic: all pointers are BRAM_ADDR_WIDTH bits and wrap modulo 2^BRAM_ADDR_WIDTH with no special case.
- Counters are 32 bits and wrap from 0xFFFFFFFF to 0.
- `clear_stats`: zeroes `packets_written`, `packets_dropped` and both sticky flags. If it coincides with an increment or a flag set, the clear wins. It does not affect pointers or the FSM.
- `enable` deasserting mid-packet has no effect until the end flag is seen; the current packet completes normally.

## Timing
- Reset values:
  - State IDLE; `wr_ptr`=0, `committed_write_ptr`=0.
  - All counters 0; both sticky flags 0; `in_packet`=0; `drop`=0.
  - `fifo_read_en`, `bram_en` and `bram_we` are 0; `bram_addr`=0 and `bram_wdata`=0.
- All outputs are registered.
- `rst` asserted mid-packet abandons the packet: it is not committed and not counted. The FIFO is not flushed by this block.
- Per 64-bit word: 4 cycles (FETCH, LATCH, WR_LO, WR_HI); the pipeline is not overlapped.
- A 37-word packet takes 148 cycles, well inside the 2800-cycle packet interval.
- `fifo_read_en` is never asserted while `fifo_empty`=1 in the same cycle.
- `committed_write_ptr` updates in the cycle after WR_HI of the end word. That is 4 cycles after the FETCH of the end word.
- `ps_read_ptr` is sampled only in LATCH for the first word of a packet.

## Test plan
- Single packet, `enable`=1, `ps_read_ptr`=0, 37 words with the end flag on word 37:
  - 74 BRAM writes to addresses 0..73, low half before high half.
  - `committed_write_ptr`=74 only after the last write; `packets_written`=1.
- Overflow: `committed_write_ptr`=0, `ps_read_ptr`=50, 37-word packet arrives:
  - no BRAM writes; FIFO is fully drained.
  - `packets_dropped`=1, `overflow_sticky`=1, pointer unchanged.
- Wrap-around with BRAM_ADDR_WIDTH=8, `wr_ptr`=`committed_write_ptr`=250, `ps_read_ptr`=200:
  - writes to addresses 250..255, then 0..67; `committed_write_ptr`=68.
- Length error: packet of 38 words (76 halves), `ps_read_ptr` far ahead:
  - writes stop after 74; `wr_ptr` rolls back.
  - `length_error_sticky`=1, `packets_dropped`=1, `committed_write_ptr` unchanged.
  - The next valid packet writes from the old committed pointer.
- `enable` dropped after word 10 of a packet: packet still commits and no further FETCH occurs. Separately, `clear_stats` in the same cycle as a commit: `packets_written` reads 0.
- `rst` pulsed during WR_LO of word 20: all outputs return to reset values, nothing is committed, and the next packet starts at address 0.

Source files
------------

// File: rtl/fifo_bram_packet_writer_if.sv
// rtl/fifo_bram_packet_writer_if.sv - FIFO read and BRAM write signal bundle
interface fifo_bram_packet_writer_if #(
  parameter int unsigned BRAM_ADDR_WIDTH = 14
);
  logic                       fifo_empty;
  logic                       fifo_read_en;
  logic [63:0]                fifo_read_data;
  logic                       fifo_read_end_flag;
  logic                       bram_en;
  logic                       bram_we;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
  logic [31:0]                bram_wdata;

  modport master (
    input  fifo_empty, fifo_read_data, fifo_read_end_flag,
    output fifo_read_en, bram_en, bram_we, bram_addr, bram_wdata
  );

  modport slave (
    output fifo_empty, fifo_read_data, fifo_read_end_flag,
    input  fifo_read_en, bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/fifo_bram_packet_writer.sv
// rtl/fifo_bram_packet_writer.sv - drains the 64-bit packet FIFO into a 32-bit BRAM ring
module fifo_bram_packet_writer #(
  parameter int unsigned BRAM_ADDR_WIDTH = 14,
  parameter int unsigned PACKET_WORDS    = 74
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       clear_stats,
  fifo_bram_packet_writer_if.master  bus,
  input  logic [BRAM_ADDR_WIDTH-1:0] ps_read_ptr,
  output logic [BRAM_ADDR_WIDTH-1:0] committed_write_ptr,
  output logic [31:0]                packets_written,
  output logic [31:0]                packets_dropped,
  output logic                       overflow_sticky,
  output logic                       length_error_sticky,
  output logic                       in_packet
);
  localparam int unsigned AW    = BRAM_ADDR_WIDTH;
  localparam int unsigned CNT_W = $clog2(PACKET_WORDS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, WR_LO, WR_HI, DRAIN} state_t;

  state_t           state;
  state_t           state_next;
  logic [AW-1:0]    wr_ptr;
  logic [CNT_W-1:0] half_cnt;
  logic [63:0]      data_q;
  logic             end_q;
  logic             drop;

  logic [AW-1:0]    free_words;
  logic             admit;
  logic             len_exceeded;
  logic             in_packet_next;
  logic             more_work;

  logic             read_en_d;
  logic             we_d;
  logic [AW-1:0]    addr_d;
  logic [31:0]      wdata_d;

  // One slot stays empty so that equal pointers always mean an empty ring.
  assign free_words     = ps_read_ptr - committed_write_ptr - AW'(1);
  assign admit          = 32'(free_words) >= 32'(PACKET_WORDS);
  assign len_exceeded   = 32'(half_cnt) == 32'(PACKET_WORDS);
  assign in_packet_next = end_q ? 1'b0 : in_packet;
  assign more_work      = !bus.fifo_empty && (in_packet_next || enable);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!bus.fifo_empty && (in_packet || enable)) state_next = FETCH;
      FETCH: state_next = LATCH;
      LATCH: begin
        if (!in_packet) state_next = admit ? WR_LO : DRAIN;
        else            state_next = drop ? DRAIN : WR_LO;
      end
      WR_LO: state_next = len_exceeded ? DRAIN : WR_HI;
      WR_HI: state_next = more_work ? FETCH : IDLE;
      DRAIN: state_next = more_work ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded here, registered below, so every port is driven straight from a flop.
  always_comb begin
    read_en_d = (state_next == FETCH);
    we_d      = 1'b0;
    addr_d    = bus.bram_addr;
    wdata_d   = bus.bram_wdata;
    case (state)
      WR_LO: begin
        if (!len_exceeded) begin
          we_d    = 1'b1;
          addr_d  = wr_ptr;
          wdata_d = data_q[31:0];
        end
      end
      WR_HI: begin
        we_d    = 1'b1;
        addr_d  = wr_ptr;
        wdata_d = data_q[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr              <= '0;
      committed_write_ptr <= '0;
      half_cnt            <= '0;
      data_q              <= '0;
      end_q               <= 1'b0;
      drop                <= 1'b0;
      in_packet           <= 1'b0;
      packets_written     <= '0;
      packets_dropped     <= '0;
      overflow_sticky     <= 1'b0;
      length_error_sticky <= 1'b0;
      bus.fifo_read_en    <= 1'b0;
      bus.bram_en         <= 1'b0;
      bus.bram_we         <= 1'b0;
      bus.bram_addr       <= '0;
      bus.bram_wdata      <= '0;
    end else begin
      bus.fifo_read_en <= read_en_d;
      bus.bram_en      <= we_d;
      bus.bram_we      <= we_d;
      bus.bram_addr    <= addr_d;
      bus.bram_wdata   <= wdata_d;
      case (state)
        LATCH: begin
          data_q <= bus.fifo_read_data;
          end_q  <= bus.fifo_read_end_flag;
          if (!in_packet) begin
            in_packet <= 1'b1;
            half_cnt  <= '0;
            if (!admit) begin
              drop            <= 1'b1;
              overflow_sticky <= 1'b1;
            end
          end
        end
        WR_LO: begin
          // Oversized packet: forget everything written since the last commit.
          if (len_exceeded) begin
            length_error_sticky <= 1'b1;
            wr_ptr              <= committed_write_ptr;
            drop                <= 1'b1;
          end else begin
            wr_ptr   <= wr_ptr + AW'(1);
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end
        WR_HI: begin
          wr_ptr   <= wr_ptr + AW'(1);
          half_cnt <= half_cnt + CNT_W'(1);
          if (end_q) begin
            committed_write_ptr <= wr_ptr + AW'(1);
            packets_written     <= packets_written + 32'd1;
            in_packet           <= 1'b0;
          end
        end
        DRAIN: begin
          if (end_q) begin
            packets_dropped <= packets_dropped + 32'd1;
            in_packet       <= 1'b0;
            drop            <= 1'b0;
          end
        end
        default: ;
      endcase
      if (clear_stats) begin
        packets_written     <= '0;
        packets_dropped     <= '0;
        overflow_sticky     <= 1'b0;
        length_error_sticky <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fifo_bram_packet_writer.sv
// tb/tb_fifo_bram_packet_writer.sv - scoreboard bench for fifo_bram_packet_writer
module tb_fifo_bram_packet_writer;
  localparam int AW = 8;
  localparam int PW = 74;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          clear_stats;
  logic [AW-1:0] ps_read_ptr;
  logic [AW-1:0] committed_write_ptr;
  logic [31:0]   packets_written;
  logic [31:0]   packets_dropped;
  logic          overflow_sticky;
  logic          length_error_sticky;
  logic          in_packet;

  fifo_bram_packet_writer_if #(.BRAM_ADDR_WIDTH(AW)) bus ();

  fifo_bram_packet_writer #(.BRAM_ADDR_WIDTH(AW), .PACKET_WORDS(PW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .clear_stats         (clear_stats),
    .bus                 (bus),
    .ps_read_ptr         (ps_read_ptr),
    .committed_write_ptr (committed_write_ptr),
    .packets_written     (packets_written),
    .packets_dropped     (packets_dropped),
    .overflow_sticky     (overflow_sticky),
    .length_error_sticky (length_error_sticky),
    .in_packet           (in_packet)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  bit            in_reset = 1'b1;
  logic [64:0]   fifo_q[$];
  logic [39:0]   exp_wr[$];
  logic [AW-1:0] exp_cm[$];
  logic [AW-1:0] m_cm = '0;
  logic [AW-1:0] last_cm = '0;
  logic [31:0]   m_pw = '0;
  logic [31:0]   m_pd = '0;
  bit            m_ovf = 1'b0;
  bit            m_len = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor and FIFO model share one block so pop order and checks never race.
  always @(negedge clk) begin
    logic [64:0] w;
    logic [39:0] e;
    if (in_reset) begin
      last_cm = committed_write_ptr;
    end else begin
      if (bus.fifo_read_en) check("fetch_nonempty", 64'(fifo_q.size() != 0), 64'd1);
      if (bus.bram_en || bus.bram_we) check("bram_en_eq_we", 64'(bus.bram_en), 64'(bus.bram_we));
      if (bus.bram_we) begin
        if (exp_wr.size() == 0) begin
          check("unexpected_write_addr", 64'(bus.bram_addr), 64'hFFFF);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", 64'(bus.bram_addr), 64'(e[39:32]));
          check("wr_data", 64'(bus.bram_wdata), 64'(e[31:0]));
        end
      end
      if (committed_write_ptr != last_cm) begin
        if (exp_cm.size() == 0) check("unexpected_commit", 64'(committed_write_ptr), 64'(last_cm));
        else check("commit_ptr", 64'(committed_write_ptr), 64'(exp_cm.pop_front()));
        check("commit_after_writes", 64'(exp_wr.size()), 64'd0);
        last_cm = committed_write_ptr;
      end
    end
    if (bus.fifo_read_en && fifo_q.size() != 0) begin
      w = fifo_q.pop_front();
      bus.fifo_read_data     = w[63:0];
      bus.fifo_read_end_flag = w[64];
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  end

  // Reference: a packet is admitted if the ring has room for a full-size packet,
  // writes at most PW halves from the committed pointer, and commits only if it fits.
  task automatic send(input int n, input logic [AW-1:0] ps);
    logic [AW-1:0] free;
    logic [63:0]   d;
    bit            admit;
    ps_read_ptr = ps;
    free  = ps - m_cm - AW'(1);
    admit = (int'(free) >= PW);
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      fifo_q.push_back({(i == n - 1), d});
      if (admit && i < PW / 2) begin
        exp_wr.push_back({m_cm + AW'(2 * i), d[31:0]});
        exp_wr.push_back({m_cm + AW'(2 * i + 1), d[63:32]});
      end
    end
    if (!admit) begin
      m_pd++;
      m_ovf = 1'b1;
    end else if (2 * n > PW) begin
      m_pd++;
      m_len = 1'b1;
    end else begin
      m_cm = m_cm + AW'(2 * n);
      exp_cm.push_back(m_cm);
      m_pw++;
    end
  endtask

  task automatic wait_idle();
    int stable = 0;
    int cyc = 0;
    while (stable < 6 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (fifo_q.size() == 0 && !in_packet && !bus.fifo_read_en && !bus.bram_we) stable++;
      else stable = 0;
    end
    if (stable < 6) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_fetches(input int k);
    int seen = 0;
    int cyc = 0;
    while (seen < k && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.fifo_read_en) seen++;
    end
    if (seen < k) check("fetch_timeout", 64'(seen), 64'(k));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_committed"}, 64'(committed_write_ptr), 64'(m_cm));
    check({tag, "_written"}, 64'(packets_written), 64'(m_pw));
    check({tag, "_dropped"}, 64'(packets_dropped), 64'(m_pd));
    check({tag, "_overflow"}, 64'(overflow_sticky), 64'(m_ovf));
    check({tag, "_lenerr"}, 64'(length_error_sticky), 64'(m_len));
    check({tag, "_in_packet"}, 64'(in_packet), 64'd0);
    check({tag, "_pending_writes"}, 64'(exp_wr.size()), 64'd0);
    check({tag, "_pending_commits"}, 64'(exp_cm.size()), 64'd0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_read_en"}, 64'(bus.fifo_read_en), 64'd0);
    check({tag, "_bram_en"}, 64'(bus.bram_en), 64'd0);
    check({tag, "_bram_we"}, 64'(bus.bram_we), 64'd0);
    check({tag, "_bram_addr"}, 64'(bus.bram_addr), 64'd0);
    check({tag, "_bram_wdata"}, 64'(bus.bram_wdata), 64'd0);
    check({tag, "_committed"}, 64'(committed_write_ptr), 64'd0);
    check({tag, "_written"}, 64'(packets_written), 64'd0);
    check({tag, "_dropped"}, 64'(packets_dropped), 64'd0);
    check({tag, "_overflow"}, 64'(overflow_sticky), 64'd0);
    check({tag, "_lenerr"}, 64'(length_error_sticky), 64'd0);
    check({tag, "_in_packet"}, 64'(in_packet), 64'd0);
  endtask

  initial begin
    int fetches;
    rst         = 1'b1;
    enable      = 1'b1;
    clear_stats = 1'b0;
    ps_read_ptr = '0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;

    send(37, 8'd0);
    wait_idle();
    check_model("single");

    send(37, m_cm + AW'(50));
    wait_idle();
    check_model("overflow");
    check("overflow_fifo_drained", 64'(fifo_q.size()), 64'd0);

    send(38, m_cm + AW'(200));
    wait_idle();
    check_model("length_error");
    send(5, m_cm + AW'(200));
    wait_idle();
    check_model("after_length_error");

    for (int p = 0; p < 25; p++) begin
      send($urandom_range(1, 40), AW'($urandom_range(0, 255)));
      wait_idle();
      check_model("random");
    end

    send(20, m_cm - AW'(1));
    wait_fetches(10);
    enable = 1'b0;
    wait_idle();
    check_model("enable_drop");
    send(3, m_cm - AW'(1));
    fetches = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.fifo_read_en) fetches++;
    end
    check("disabled_no_fetch", 64'(fetches), 64'd0);
    check("disabled_fifo_kept", 64'(fifo_q.size()), 64'd3);
    enable = 1'b1;
    wait_idle();
    check_model("reenable");

    begin
      logic [AW-1:0] target;
      int cyc;
      target = m_cm + AW'(2 * 8 - 2);
      send(8, m_cm - AW'(1));
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(bus.bram_we && bus.bram_addr == target) && cyc < 1000);
      if (cyc >= 1000) check("clear_target_timeout", 64'd1, 64'd0);
      clear_stats = 1'b1;
      @(negedge clk);
      clear_stats = 1'b0;
      m_pw = '0; m_pd = '0; m_ovf = 1'b0; m_len = 1'b0;
      wait_idle();
      check_model("clear_with_commit");
    end

    send(30, m_cm - AW'(1));
    wait_fetches(20);
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    in_reset = 1'b1;
    @(negedge clk);
    reset_checks("midpacket_reset");
    check("writes_before_reset", 64'(exp_wr.size()), 64'd22);
    fifo_q.delete();
    exp_wr.delete();
    exp_cm.delete();
    m_cm = '0; m_pw = '0; m_pd = '0; m_ovf = 1'b0; m_len = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    in_reset = 1'b0;

    send(37, m_cm - AW'(1));
    wait_idle();
    send(37, m_cm - AW'(1));
    wait_idle();
    send(37, m_cm - AW'(1));
    wait_idle();
    send(14, m_cm - AW'(1));
    wait_idle();
    check_model("pre_wrap");
    send(37, AW'(200));
    wait_idle();
    check_model("wrap");
    check("wrap_commit_value", 64'(committed_write_ptr), 64'd68);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
